twiddle_seq_ctrl: RTL and testbench

- Sequences the 16-lane twiddle BROM (128×192b, 1-cycle read latency) for one Kyber polynomial operation: forward NTT, inverse NTT or pointwise multiply.
- On start it issues the ROM read address each cycle, marks when the ROM output is valid for the 16 PEs, and reports stage and cycle-in-stage alongside the data.
- Sits between the top-level operation FSM and the BROM; one instance per 16-PE core.

---
 rtl/kyber_twid_pkg.sv | 23 ++
 rtl/twid_addr_map.sv | 45 ++++
 rtl/twiddle_seq_ctrl.sv | 147 ++++++++++++++
 tb/tb_twiddle_seq_ctrl.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/kyber_twid_pkg.sv
// Shared constants, mode encodings and FSM states for the twiddle ROM sequencer.
// Stall support is compiled in with TWID_STALL_EN.
package kyber_twid_pkg;

   localparam int ROM_ADDR_W    = 7;
   localparam int NUM_STAGES    = 7;
   localparam int CYC_PER_STAGE = 8;

   localparam logic [1:0] MODE_NTT  = 2'd0;
   localparam logic [1:0] MODE_INTT = 2'd1;
   localparam logic [1:0] MODE_PWM  = 2'd2;

   localparam int W_BASE_DEF    = 0;
   localparam int WINV_BASE_DEF = 39;
   localparam int WP_BASE_DEF   = 78;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_RUN,
      ST_GAP
   } state_t;

endpackage

// File: rtl/twid_addr_map.sv
// Combinational (mode, stage, cyc) to ROM row offset within the mode's region.
// Stall support (TWID_STALL_EN) does not affect this block.
module twid_addr_map
   import kyber_twid_pkg::*;
(
   input  logic [1:0]            mode,
   input  logic [2:0]            stage,
   input  logic [2:0]            cyc,
   output logic [ROM_ADDR_W-1:0] offset
);

   logic [6:0] c7;
   logic [6:0] s7;

   assign c7 = {4'd0, cyc};
   assign s7 = {4'd0, stage};

   always_comb begin
      offset = '0;
      unique case (mode)
         MODE_NTT: begin
            // early stages reuse each twiddle across several cycles
            case (stage)
               3'd0:    offset = 7'd0;
               3'd1:    offset = 7'd1 + (c7 >> 2);
               3'd2:    offset = 7'd3 + (c7 >> 1);
               3'd3:    offset = 7'd7 + c7;
               default: offset = 7'd15 + ((s7 - 7'd4) << 3) + c7;
            endcase
         end
         MODE_INTT: begin
            case (stage)
               3'd4:    offset = 7'd32 + (c7 >> 1);
               3'd5:    offset = 7'd36 + (c7 >> 2);
               3'd6:    offset = 7'd38;
               3'd7:    offset = 7'd0;
               default: offset = (s7 << 3) + c7;
            endcase
         end
         MODE_PWM: offset = c7;
         default:  offset = 7'd0;
      endcase
   end

endmodule

// File: rtl/twiddle_seq_ctrl.sv
// Twiddle BROM sequencer for one 16-PE core: NTT, INTT or pointwise multiply.
// Define TWID_STALL_EN to add the stall port that freezes issue.
module twiddle_seq_ctrl
   import kyber_twid_pkg::*;
#(
   parameter int GAP_CYC   = 0,
   parameter int W_BASE    = W_BASE_DEF,
   parameter int WINV_BASE = WINV_BASE_DEF,
   parameter int WP_BASE   = WP_BASE_DEF
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   input  logic [1:0]            mode,
`ifdef TWID_STALL_EN
   input  logic                  stall,
`endif
   output logic [ROM_ADDR_W-1:0] raddr,
   output logic                  tw_valid,
   output logic [2:0]            tw_stage,
   output logic [2:0]            tw_cyc,
   output logic                  busy,
   output logic                  done
);

   state_t state, state_n;
   logic [1:0] mode_q, mode_n;
   logic [2:0] stage, stage_n;
   logic [2:0] cyc, cyc_n;
   logic [3:0] gap, gap_n;
   logic hold, issue, accept;
   logic last_stage, last_cyc, last_issue, load;
   logic [ROM_ADDR_W-1:0] offset, base;

`ifdef TWID_STALL_EN
   assign hold = stall;
`else
   assign hold = 1'b0;
`endif

   assign accept = (state == ST_IDLE) && !busy
                 && start && (mode != 2'd3);
   assign last_cyc   = (cyc == 3'(CYC_PER_STAGE - 1));
   assign last_stage = (mode_q == MODE_PWM) ? (stage == 3'd0)
                     : (stage == 3'(NUM_STAGES - 1));
   assign issue      = (state == ST_RUN) && !hold;
   assign last_issue = issue && last_cyc && last_stage;

   // next cursor drives the map so raddr is ready in the issue cycle
   always_comb begin
      state_n = state;
      mode_n  = mode_q;
      stage_n = stage;
      cyc_n   = cyc;
      gap_n   = gap;
      load    = 1'b0;
      unique case (state)
         ST_IDLE: begin
            if (accept) begin
               state_n = ST_RUN;
               mode_n  = mode;
               stage_n = 3'd0;
               cyc_n   = 3'd0;
               load    = 1'b1;
            end
         end
         ST_RUN: begin
            if (!hold) begin
               if (!last_cyc) begin
                  cyc_n = cyc + 3'd1;
                  load  = 1'b1;
               end else if (last_stage) begin
                  state_n = ST_IDLE;
               end else if (GAP_CYC > 0) begin
                  state_n = ST_GAP;
                  gap_n   = 4'd0;
               end else begin
                  stage_n = stage + 3'd1;
                  cyc_n   = 3'd0;
                  load    = 1'b1;
               end
            end
         end
         ST_GAP: begin
            if (!hold) begin
               if (gap == 4'(GAP_CYC - 1)) begin
                  state_n = ST_RUN;
                  stage_n = stage + 3'd1;
                  cyc_n   = 3'd0;
                  load    = 1'b1;
               end else begin
                  gap_n = gap + 4'd1;
               end
            end
         end
         default: state_n = ST_IDLE;
      endcase
   end

   always_comb begin
      base = 7'(W_BASE);
      unique case (mode_n)
         MODE_INTT: base = 7'(WINV_BASE);
         MODE_PWM:  base = 7'(WP_BASE);
         default:   base = 7'(W_BASE);
      endcase
   end

   twid_addr_map u_map (
      .mode   (mode_n),
      .stage  (stage_n),
      .cyc    (cyc_n),
      .offset (offset)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= ST_IDLE;
         mode_q   <= MODE_NTT;
         stage    <= '0;
         cyc      <= '0;
         gap      <= '0;
         raddr    <= '0;
         tw_valid <= 1'b0;
         tw_stage <= '0;
         tw_cyc   <= '0;
         busy     <= 1'b0;
         done     <= 1'b0;
      end else begin
         state    <= state_n;
         mode_q   <= mode_n;
         stage    <= stage_n;
         cyc      <= cyc_n;
         gap      <= gap_n;
         if (load)
            raddr <= base + offset;
         tw_valid <= issue;
         if (issue) begin
            tw_stage <= stage;
            tw_cyc   <= cyc;
         end
         busy     <= (state_n != ST_IDLE) || last_issue;
         done     <= last_issue;
      end
   end

endmodule

// File: tb/tb_twiddle_seq_ctrl.sv
// Directed bench for twiddle_seq_ctrl (GAP_CYC=0 and GAP_CYC=3 instances).
// Stall scenario runs only when TWID_STALL_EN is defined.
module tb_twiddle_seq_ctrl;

   logic clk = 1'b0;
   logic reset;
   logic start0, start3;
   logic [1:0] mode;
`ifdef TWID_STALL_EN
   logic stall;
`endif

   logic [6:0] raddr0, raddr3;
   logic tw_valid0, tw_valid3;
   logic [2:0] tw_stage0, tw_stage3;
   logic [2:0] tw_cyc0, tw_cyc3;
   logic busy0, busy3, done0, done3;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   twiddle_seq_ctrl #(.GAP_CYC(0)) dut0 (
      .clk      (clk),
      .reset    (reset),
      .start    (start0),
      .mode     (mode),
`ifdef TWID_STALL_EN
      .stall    (stall),
`endif
      .raddr    (raddr0),
      .tw_valid (tw_valid0),
      .tw_stage (tw_stage0),
      .tw_cyc   (tw_cyc0),
      .busy     (busy0),
      .done     (done0)
   );

   twiddle_seq_ctrl #(.GAP_CYC(3)) dut3 (
      .clk      (clk),
      .reset    (reset),
      .start    (start3),
      .mode     (mode),
`ifdef TWID_STALL_EN
      .stall    (1'b0),
`endif
      .raddr    (raddr3),
      .tw_valid (tw_valid3),
      .tw_stage (tw_stage3),
      .tw_cyc   (tw_cyc3),
      .busy     (busy3),
      .done     (done3)
   );

   // hand-written row tables: issue index i = 8*stage + cyc
   function automatic logic [6:0] ntt_row(input int i);
      int s, c;
      s = i / 8;
      c = i % 8;
      case (s)
         0:       return 7'd0;
         1:       return (c < 4) ? 7'd1 : 7'd2;
         2:       return 7'(3 + c / 2);
         default: return 7'(7 + 8 * (s - 3) + c);
      endcase
   endfunction

   function automatic logic [6:0] intt_row(input int i);
      int s, c;
      s = i / 8;
      c = i % 8;
      if (s < 4) return 7'(39 + i);
      if (s == 4) return 7'(71 + c / 2);
      if (s == 5) return (c < 4) ? 7'd75 : 7'd76;
      return 7'd77;
   endfunction

   function automatic logic [6:0] exp_row(input logic [1:0] m, input int i);
      if (m == 2'd0) return ntt_row(i);
      if (m == 2'd1) return intt_row(i);
      return 7'(78 + i);
   endfunction

   task automatic test_reset();
      reset  = 1'b1;
      start0 = 1'b0;
      start3 = 1'b0;
      mode   = 2'd0;
`ifdef TWID_STALL_EN
      stall  = 1'b0;
`endif
      repeat (2) @(posedge clk);
      @(negedge clk);
      checks++;
      if ({raddr0, tw_valid0, tw_stage0, tw_cyc0, busy0, done0} !== 16'd0) begin
         errors++;
         $display("FAIL reset_outs: got %h want 0",
                  {raddr0, tw_valid0, tw_stage0, tw_cyc0, busy0, done0});
      end
      checks++;
      if ({raddr3, tw_valid3, busy3, done3} !== 10'd0) begin
         errors++;
         $display("FAIL reset_outs3: got %h want 0",
                  {raddr3, tw_valid3, busy3, done3});
      end
      reset = 1'b0;
   endtask

   // start at cycle 0, sample each later cycle at the falling edge
   task automatic test_sequence(input logic [1:0] m, input int nst);
      int last;
      logic ev;
      last = nst * 8;
      for (int n = 0; n <= last + 3; n++) begin
         @(negedge clk);
         if (n >= 1) begin
            ev = (n >= 2) && (n <= last + 1);
            checks++;
            if (tw_valid0 !== ev) begin
               errors++;
               $display("FAIL seq%0d_valid cyc %0d: got %b want %b", m, n, tw_valid0, ev);
            end
            checks++;
            if (done0 !== (n == last + 1)) begin
               errors++;
               $display("FAIL seq%0d_done cyc %0d: got %b", m, n, done0);
            end
            checks++;
            if (busy0 !== (n <= last + 1)) begin
               errors++;
               $display("FAIL seq%0d_busy cyc %0d: got %b", m, n, busy0);
            end
            checks++;
            if (raddr0 !== exp_row(m, (n <= last) ? n - 1 : last - 1)) begin
               errors++;
               $display("FAIL seq%0d_raddr cyc %0d: got %0d want %0d", m, n, raddr0,
                        exp_row(m, (n <= last) ? n - 1 : last - 1));
            end
            if (ev) begin
               checks++;
               if (tw_stage0 !== 3'((n - 2) / 8) || tw_cyc0 !== 3'((n - 2) % 8)) begin
                  errors++;
                  $display("FAIL seq%0d_tag cyc %0d: got %0d/%0d want %0d/%0d", m, n,
                           tw_stage0, tw_cyc0, (n - 2) / 8, (n - 2) % 8);
               end
            end
         end
         start0 = (n == 0);
         mode   = m;
      end
   endtask

   task automatic test_mode3();
      for (int n = 0; n <= 5; n++) begin
         @(negedge clk);
         if (n >= 1) begin
            checks++;
            if (busy0 !== 1'b0 || done0 !== 1'b0 || tw_valid0 !== 1'b0) begin
               errors++;
               $display("FAIL mode3 cyc %0d: got busy %b done %b valid %b want 0",
                        n, busy0, done0, tw_valid0);
            end
         end
         start0 = (n == 0);
         mode   = 2'd3;
      end
   endtask

   // issue i happens in cycle 1 + i + 3*(i/8)
   task automatic test_gap();
      logic ev, iss;
      int ei, ii;
      for (int n = 0; n <= 78; n++) begin
         @(negedge clk);
         if (n >= 1) begin
            ev = 1'b0; iss = 1'b0; ei = 0; ii = 0;
            for (int i = 0; i < 56; i++) begin
               if (2 + i + 3 * (i / 8) == n) begin ev = 1'b1; ei = i; end
               if (1 + i + 3 * (i / 8) == n) begin iss = 1'b1; ii = i; end
            end
            checks++;
            if (tw_valid3 !== ev) begin
               errors++;
               $display("FAIL gap_valid cyc %0d: got %b want %b", n, tw_valid3, ev);
            end
            checks++;
            if (done3 !== (n == 75) || busy3 !== (n <= 75)) begin
               errors++;
               $display("FAIL gap_done_busy cyc %0d: got %b%b", n, done3, busy3);
            end
            if (iss) begin
               checks++;
               if (raddr3 !== ntt_row(ii)) begin
                  errors++;
                  $display("FAIL gap_raddr cyc %0d: got %0d want %0d", n, raddr3, ntt_row(ii));
               end
            end
            if (ev) begin
               checks++;
               if (tw_stage3 !== 3'(ei / 8) || tw_cyc3 !== 3'(ei % 8)) begin
                  errors++;
                  $display("FAIL gap_tag cyc %0d: got %0d/%0d want %0d/%0d", n,
                           tw_stage3, tw_cyc3, ei / 8, ei % 8);
               end
            end
         end
         start3 = (n == 0) || (n == 20);
         mode   = (n == 20) ? 2'd2 : 2'd0;
      end
      start3 = 1'b0;
   endtask

   task automatic test_reset_mid();
      bit seen;
      for (int n = 0; n <= 40; n++) begin
         @(negedge clk);
         if (n >= 1) begin
            checks++;
            if (done0 !== 1'b0) begin
               errors++;
               $display("FAIL rst_nodone cyc %0d: got %b want 0", n, done0);
            end
            if (n >= 31 && n <= 33) begin
               checks++;
               if ({raddr0, tw_valid0, tw_stage0, tw_cyc0, busy0} !== 15'd0) begin
                  errors++;
                  $display("FAIL rst_zero cyc %0d: got %h want 0", n,
                           {raddr0, tw_valid0, tw_stage0, tw_cyc0, busy0});
               end
            end
            if (n == 34) begin
               checks++;
               if (raddr0 !== 7'd0 || busy0 !== 1'b1) begin
                  errors++;
                  $display("FAIL rst_restart: got raddr %0d busy %b want 0/1", raddr0, busy0);
               end
            end
         end
         start0 = (n == 0) || (n == 33);
         reset  = (n == 30);
         mode   = 2'd0;
      end
      start0 = 1'b0;
      seen = 1'b0;
      for (int k = 0; k < 80 && !seen; k++) begin
         @(negedge clk);
         if (done0) seen = 1'b1;
      end
      checks++;
      if (!seen) begin
         errors++;
         $display("FAIL rst_rerun_done: got no done within 80 cycles want done");
      end
      repeat (2) @(negedge clk);
   endtask

`ifdef TWID_STALL_EN
   task automatic test_stall();
      logic ev, iss;
      int ii;
      for (int n = 0; n <= 62; n++) begin
         @(negedge clk);
         if (n >= 1) begin
            ev = 1'b0; iss = 1'b0; ii = 0;
            for (int i = 0; i < 56; i++) begin
               if (2 + i + ((i >= 9) ? 3 : 0) == n) ev = 1'b1;
               if (1 + i + ((i >= 9) ? 3 : 0) == n) begin iss = 1'b1; ii = i; end
            end
            checks++;
            if (tw_valid0 !== ev || done0 !== (n == 60)) begin
               errors++;
               $display("FAIL stall_valid_done cyc %0d: got %b%b want %b%b",
                        n, tw_valid0, done0, ev, (n == 60));
            end
            if (iss) begin
               checks++;
               if (raddr0 !== ntt_row(ii)) begin
                  errors++;
                  $display("FAIL stall_raddr cyc %0d: got %0d want %0d", n, raddr0, ntt_row(ii));
               end
            end
         end
         start0 = (n == 0);
         stall  = (n >= 10) && (n <= 12);
         mode   = 2'd0;
      end
      stall = 1'b0;
   endtask
`endif

   initial begin
      test_reset();
      test_sequence(2'd0, 7);
      test_sequence(2'd1, 7);
      test_sequence(2'd2, 1);
      test_mode3();
      test_gap();
      test_reset_mid();
`ifdef TWID_STALL_EN
      test_stall();
`endif
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
